// File: rtl/piso_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : piso_ctrl_pkg
// Description : Shared state encoding and requester count for the PISO arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package piso_ctrl_pkg;

    localparam int unsigned NUM_REQ = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/piso_core.sv
`default_nettype none
// ============================================================================
// Module      : piso_core
// Description : Parallel-load shift register, shifts toward LSB with zero fill.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_core
    import piso_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    output logic             sout
);

    logic [WIDTH-1:0] r_shreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg <= '0;
        end else if (load) begin
            r_shreg <= load_data;
        end else if (shift) begin
            r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
        end
    end

    assign sout = r_shreg[0];

endmodule
`default_nettype wire

// File: rtl/piso_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : piso_arb_ctrl
// Description : Two-requester round-robin arbiter feeding an LSB-first
//               serializer with optional inter-frame gap.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_arb_ctrl
    import piso_ctrl_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_first,
    output logic             sout_last,
    output logic             grant_id,
    output logic             busy
);

    localparam int SEL_W = $clog2(NUM_REQ);
    localparam int BIT_W = $clog2(WIDTH);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int c_GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [BIT_W-1:0] c_BIT_LAST = BIT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] c_GAP_LAST = c_GAP_LAST_I[GAP_W-1:0];

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_prio;
    logic               r_grant_id;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [SEL_W-1:0]   w_sel;
    logic               w_accept;
    logic               w_shift;
    logic               w_bit_last;
    logic               w_gap_last;
    logic               w_core_sout;

    // Contention falls back to the round-robin pointer; a lone valid always wins.
    assign w_sel      = (req0_valid & req1_valid) ? r_prio : req1_valid;
    assign w_accept   = (r_state == ST_IDLE) & (req0_valid | req1_valid) & ~rst;
    assign w_bit_last = (r_bit_cnt == c_BIT_LAST);
    assign w_gap_last = (r_gap_cnt == c_GAP_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_shift = 1'b1;
                if (w_bit_last) begin
                    w_state_nxt = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (w_gap_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio     <= 1'b0;
            r_grant_id <= 1'b0;
            r_bit_cnt  <= '0;
            r_gap_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_grant_id <= w_sel;
                r_prio     <= ~w_sel;
                r_bit_cnt  <= '0;
            end else if (r_state == ST_SHIFT) begin
                r_bit_cnt <= w_bit_last ? '0 : r_bit_cnt + 1'b1;
            end

            if (r_state == ST_GAP) begin
                r_gap_cnt <= w_gap_last ? '0 : r_gap_cnt + 1'b1;
            end else begin
                r_gap_cnt <= '0;
            end
        end
    end

    piso_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (w_accept),
        .load_data (w_sel ? req1_data : req0_data),
        .shift     (w_shift),
        .sout      (w_core_sout)
    );

    // Readies are masked by rst so every output reads 0 while reset is held.
    assign req0_ready = w_accept & ~w_sel;
    assign req1_ready = w_accept & w_sel;
    assign sout_valid = (r_state == ST_SHIFT);
    assign sout       = sout_valid & w_core_sout;
    assign sout_first = sout_valid & (r_bit_cnt == '0);
    assign sout_last  = sout_valid & w_bit_last;
    assign grant_id   = r_grant_id;
    assign busy       = (r_state == ST_SHIFT) | (r_state == ST_GAP);

endmodule
`default_nettype wire

// File: tb/tb_piso_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_arb_ctrl
// Description : Directed self-checking bench for piso_arb_ctrl in three
//               parameter sets (4/1, 4/0, 8/1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_arb_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance a: WIDTH=4, GAP=1
    logic       a_rst, a_v0, a_v1, a_r0, a_r1;
    logic [3:0] a_d0, a_d1;
    logic       a_sout, a_sv, a_sf, a_sl, a_gid, a_busy;
    // Instance b: WIDTH=4, GAP=0
    logic       b_rst, b_v0, b_v1, b_r0, b_r1;
    logic [3:0] b_d0, b_d1;
    logic       b_sout, b_sv, b_sf, b_sl, b_gid, b_busy;
    // Instance c: WIDTH=8, GAP=1
    logic       c_rst, c_v0, c_v1, c_r0, c_r1;
    logic [7:0] c_d0, c_d1;
    logic       c_sout, c_sv, c_sf, c_sl, c_gid, c_busy;

    piso_arb_ctrl #(.WIDTH(4), .GAP_CYCLES(1)) u_dut_a (
        .clk(clk), .rst(a_rst),
        .req0_valid(a_v0), .req0_data(a_d0), .req0_ready(a_r0),
        .req1_valid(a_v1), .req1_data(a_d1), .req1_ready(a_r1),
        .sout(a_sout), .sout_valid(a_sv), .sout_first(a_sf), .sout_last(a_sl),
        .grant_id(a_gid), .busy(a_busy)
    );

    piso_arb_ctrl #(.WIDTH(4), .GAP_CYCLES(0)) u_dut_b (
        .clk(clk), .rst(b_rst),
        .req0_valid(b_v0), .req0_data(b_d0), .req0_ready(b_r0),
        .req1_valid(b_v1), .req1_data(b_d1), .req1_ready(b_r1),
        .sout(b_sout), .sout_valid(b_sv), .sout_first(b_sf), .sout_last(b_sl),
        .grant_id(b_gid), .busy(b_busy)
    );

    piso_arb_ctrl #(.WIDTH(8), .GAP_CYCLES(1)) u_dut_c (
        .clk(clk), .rst(c_rst),
        .req0_valid(c_v0), .req0_data(c_d0), .req0_ready(c_r0),
        .req1_valid(c_v1), .req1_data(c_d1), .req1_ready(c_r1),
        .sout(c_sout), .sout_valid(c_sv), .sout_first(c_sf), .sout_last(c_sl),
        .grant_id(c_gid), .busy(c_busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Waits for a ready on instance a, checks the winner, then checks n_bits
    // serial bits as {sout_valid, sout, sout_first, sout_last, grant_id}.
    task automatic a_frame(input logic exp_id, input logic [3:0] exp_data, input int n_bits);
        int k;
        logic [4:0] exp_bus;
        k = 0;
        @(negedge clk);
        while (!(a_r0 | a_r1) && k < 20) begin
            @(negedge clk);
            k++;
        end
        check_eq("a_winner", {30'd0, a_r1, a_r0}, exp_id ? 32'd2 : 32'd1);
        @(posedge clk);
        for (int i = 0; i < n_bits; i++) begin
            @(negedge clk);
            exp_bus = {1'b1, exp_data[i], (i == 0), (i == 3), exp_id};
            check_eq($sformatf("a_bit%0d_id%0d", i, exp_id),
                     {27'd0, a_sv, a_sout, a_sf, a_sl, a_gid}, {27'd0, exp_bus});
        end
    endtask

    initial begin
        logic [3:0] d1011;
        logic [3:0] d6;
        logic [7:0] d81;
        int k;

        d1011 = 4'b1011;
        d6    = 4'h6;
        d81   = 8'h81;
        a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
        a_v0 = 1'b1; a_d0 = d1011; a_v1 = 1'b0; a_d1 = 4'h0;
        b_v0 = 1'b0; b_d0 = 4'h0;  b_v1 = 1'b0; b_d1 = 4'h0;
        c_v0 = 1'b0; c_d0 = 8'h00; c_v1 = 1'b0; c_d1 = 8'h00;

        // Reset state, with a valid present that must not raise ready
        repeat (2) @(negedge clk);
        check_eq("a_reset_outs", {24'd0, a_r0, a_r1, a_sout, a_sv, a_sf, a_sl, a_gid, a_busy}, 32'd0);
        @(posedge clk); #2;
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

        // Single request 4'b1011, held valid to probe accept spacing
        @(negedge clk);
        check_eq("a_single_ready", {31'd0, a_r0}, 32'd1);
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq($sformatf("a_single_bit%0d", i),
                     {26'd0, a_sv, a_sout, a_sf, a_sl, a_r0, a_busy},
                     {26'd0, 1'b1, d1011[i], (i == 0), (i == 3), 1'b0, 1'b1});
        end
        @(negedge clk);
        check_eq("a_single_gap", {29'd0, a_busy, a_sv, a_r0}, 32'b100);
        @(negedge clk);
        check_eq("a_single_idle", {30'd0, a_busy, a_r0}, 32'b01);
        a_v0 = 1'b0;
        @(negedge clk);
        check_eq("a_single_no_reaccept", {30'd0, a_busy, a_r0}, 32'b00);

        // Valid while busy: req1 arrives mid-frame and must wait for IDLE
        @(posedge clk); #2;
        a_v0 = 1'b1; a_d0 = 4'h3;
        @(negedge clk);
        check_eq("a_busy_r0", {31'd0, a_r0}, 32'd1);
        @(posedge clk); #2;
        a_v0 = 1'b0;
        @(negedge clk);
        check_eq("a_busy_bit0", {30'd0, a_sv, a_sout}, 32'b11);
        @(posedge clk); #2;
        a_v1 = 1'b1; a_d1 = 4'hC;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq($sformatf("a_busy_r1_low%0d", i), {30'd0, a_busy, a_r1}, 32'b10);
        end
        a_frame(1'b1, 4'hC, 4);
        @(posedge clk); #2;
        a_v1 = 1'b0;

        // Contention from reset: req0, req1, then req0 interrupted by reset
        a_rst = 1'b1;
        a_v0 = 1'b1; a_d0 = 4'hA; a_v1 = 1'b1; a_d1 = 4'h5;
        @(posedge clk); #2;
        a_rst = 1'b0;
        a_frame(1'b0, 4'hA, 4);
        a_frame(1'b1, 4'h5, 4);
        a_frame(1'b0, 4'hA, 2);
        #1 a_rst = 1'b1;
        #1 check_eq("a_midframe_reset", {26'd0, a_sv, a_sout, a_r0, a_r1, a_gid, a_busy}, 32'd0);
        @(negedge clk);
        check_eq("a_reset_held_sv", {31'd0, a_sv}, 32'd0);
        @(posedge clk); #2;
        a_rst = 1'b0;
        a_frame(1'b0, 4'hA, 4);
        @(posedge clk); #2;
        a_v0 = 1'b0; a_v1 = 1'b0;

        // GAP_CYCLES=0: continuous req1, one IDLE cycle between frames
        b_v1 = 1'b1; b_d1 = d6;
        k = 0;
        @(negedge clk);
        while (!b_r1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check_eq("b_first_ready", {31'd0, b_r1}, 32'd1);
        for (int f = 0; f < 3; f++) begin
            @(posedge clk);
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                check_eq($sformatf("b_f%0d_bit%0d", f, i),
                         {27'd0, b_busy, b_r1, b_sv, b_sout, b_gid},
                         {27'd0, 1'b1, 1'b0, 1'b1, d6[i], 1'b1});
            end
            @(negedge clk);
            check_eq($sformatf("b_f%0d_idle", f), {29'd0, b_busy, b_r1, b_sv}, 32'b010);
        end
        b_v1 = 1'b0;

        // WIDTH=8, data 8'h81
        @(posedge clk); #2;
        c_v0 = 1'b1; c_d0 = d81;
        @(negedge clk);
        check_eq("c_ready", {31'd0, c_r0}, 32'd1);
        @(posedge clk); #2;
        c_v0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq($sformatf("c_bit%0d", i),
                     {28'd0, c_sv, c_sout, c_sf, c_sl},
                     {28'd0, 1'b1, d81[i], (i == 0), (i == 7)});
        end
        @(negedge clk);
        check_eq("c_gap", {30'd0, c_busy, c_sv}, 32'b10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/piso_arb_ctrl.md
PISO_ARB_CTRL -- requirements
Module: piso_arb_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: bits per parallel word, legal range 2..16.
REQ-002 Parameter GAP_CYCLES, default 1: idle cycles inserted after each frame, legal range 0..15.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req0_valid  input  1  requester 0 has a word pending.
REQ-006 req0_data  input  WIDTH  requester 0 parallel word.
REQ-007 req0_ready  output  1  requester 0 word accepted this cycle.
REQ-008 req1_valid, req1_data, req1_ready  same directions, widths and meanings as REQ-005..007, for requester 1.
REQ-009 sout  output  1  serial data bit.
REQ-010 sout_valid  output  1  sout carries a frame bit this cycle.
REQ-011 sout_first  output  1  current bit is bit 0 of the frame.
REQ-012 sout_last  output  1  current bit is bit WIDTH-1 of the frame.
REQ-013 grant_id  output  1  requester owning the current frame; holds its last value while idle.
REQ-014 busy  output  1  high in SHIFT and GAP states.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SHIFT and GAP.
REQ-016 Handshake: a word SHALL transfer on a rising edge only when reqN_valid and reqN_ready are both high.
REQ-017 reqN_ready SHALL be combinational: high only in IDLE, and only for the requester selected by REQ-018; at most one ready is high in any cycle.
REQ-018 Arbitration in IDLE: if one valid is high, that requester SHALL win; if both are high, the requester indicated by the round-robin pointer prio SHALL win.
REQ-019 After each grant, prio SHALL point to the non-granted requester.
REQ-020 On accept: the word SHALL load into the shift register, grant_id SHALL update, bit counter SHALL clear, and the state SHALL go IDLE->SHIFT.
REQ-021 SHIFT SHALL last exactly WIDTH cycles with sout_valid=1, driving data[0] first and data[WIDTH-1] last (LSB first).
REQ-022 sout_first SHALL be high on the first SHIFT cycle only; sout_last SHALL be high on the WIDTH-th SHIFT cycle only.
REQ-023 Latency: the first bit SHALL appear on the cycle immediately after the accept edge.
REQ-024 After the last bit, the state SHALL go to GAP for GAP_CYCLES cycles, then to IDLE; if GAP_CYCLES=0, SHIFT SHALL go directly to IDLE.
REQ-025 Outside SHIFT, sout, sout_valid, sout_first and sout_last SHALL all be 0.
REQ-026 Minimum spacing between accepts SHALL be WIDTH+GAP_CYCLES+1 cycles.
REQ-027 Requests are not accepted in SHIFT or GAP; requesters hold valid and data stable until ready, and the block SHALL lose no request.
REQ-028 A valid dropped before ready SHALL have no effect on prio or state.
REQ-029 Counters SHALL be sized with $clog2 of their maximum count and SHALL never wrap during a frame.

Reset
REQ-030 When rst is asserted, the block SHALL asynchronously force: state=IDLE, shift register=0, bit and gap counters=0, prio=0, grant_id=0, and all outputs 0.
REQ-031 Reset mid-frame SHALL abort the frame with no further sout_valid; the first accept after release SHALL follow REQ-018 with prio=0.

Structure
REQ-032 The state encoding SHALL be a typedef in shared package piso_ctrl_pkg, together with the requester-count constant (2).
REQ-033 The shift register (parallel load, shift toward LSB, zero fill) SHALL be a sub-module named piso_core; the FSM, arbiter and counters SHALL live in piso_arb_ctrl.

Verification
REQ-034 Single request, WIDTH=4, GAP=1: req0 sends 4'b1011 -> req0_ready pulses once; sout=1,1,0,1 over 4 cycles; first on bit 1, last on bit 4; 1 gap cycle; next accept no earlier than 6 cycles later.
REQ-035 Contention: both valid from reset, req0=4'hA and req1=4'h5 -> order req0, req1, req0 ...; grant_id alternates; each frame is correct.
REQ-036 GAP_CYCLES=0: continuous req1 traffic -> exactly one IDLE cycle (ready high) between frames; busy low only in that cycle.
REQ-037 Reset on SHIFT cycle 2 -> outputs 0 on the same cycle; after release, both valid -> req0 wins.
REQ-038 Valid while busy: req1 raises valid during SHIFT -> req1_ready stays low until IDLE, then the word is accepted unchanged.
REQ-039 WIDTH=8, data 8'h81 -> sout=1,0,0,0,0,0,0,1, with sout_last on the 8th bit.
